// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flags, divider states
// and format helpers parametrised by exponent/fraction width.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   typedef struct packed {
      logic invalid;
      logic divzero;
      logic overflow;
      logic underflow;
      logic inexact;
   } fpu_flags_t;

   // Divider state encodings
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_UNPACK   = 4'd1;
   localparam logic [3:0] ST_SPECIAL  = 4'd2;
   localparam logic [3:0] ST_NORM     = 4'd3;
   localparam logic [3:0] ST_DIVIDE   = 4'd4;
   localparam logic [3:0] ST_POSTNORM = 4'd5;
   localparam logic [3:0] ST_ROUND    = 4'd6;
   localparam logic [3:0] ST_PACK     = 4'd7;
   localparam logic [3:0] ST_OUT      = 4'd8;

   // Canonical quiet NaN (sign 1, exponent all ones, fraction MSB 1), LSB-aligned
   function automatic logic [63:0] canonical_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
      logic [63:0] w;
      w = ((64'd1 << exp_w) - 64'd1) << man_w;
      w = w | (64'd1 << (man_w - 1));
      w = w | (64'd1 << (exp_w + man_w));
      return w;
   endfunction

   function automatic int bias(input int unsigned exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounding and packing of a normalised/denormalised mantissa
// with guard/round/sticky into an IEEE word, plus overflow/underflow/inexact.
module fp_round_pack
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                      sign,
   input  logic signed [EXP_W+1:0]   exp_in,
   input  logic [MAN_W:0]            mant,
   input  logic                      guard,
   input  logic                      round_bit,
   input  logic                      sticky,
   input  rm_e                       rm,
   output logic [EXP_W+MAN_W:0]      word,
   output logic                      overflow,
   output logic                      underflow,
   output logic                      inexact
);

   localparam int EW   = EXP_W + 2;
   localparam int MW   = MAN_W + 1;
   localparam int BIAS = bias(EXP_W);
   localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic signed [EW-1:0] ONE_E  = EW'(1);

   logic                   lost;
   logic                   inc;
   logic                   to_inf;
   logic [MW:0]            sum;
   logic [MW-1:0]          m_r;
   logic signed [EW-1:0]   e_r;
   logic [EXP_W-1:0]       e_field;

   // Round increment, carry-out renormalisation and final encoding
   always_comb begin
      lost = guard | round_bit | sticky;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & lost;
         RM_RUP:  inc = ~sign & lost;
         RM_RMM:  inc = guard;
         default: inc = guard & (round_bit | sticky | mant[0]);
      endcase
      sum = {1'b0, mant} + {{MW{1'b0}}, inc};
      if (sum[MW]) begin
         m_r = sum[MW:1];
         e_r = exp_in + ONE_E;
      end else begin
         m_r = sum[MW-1:0];
         e_r = exp_in;
      end
      overflow  = (e_r > BIAS_E);
      inexact   = lost | overflow;
      underflow = ~m_r[MW-1] & lost;
      to_inf    = (rm == RM_RNE) | (rm == RM_RMM) |
                  ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);
      e_field   = m_r[MW-1] ? EXP_W'(e_r + BIAS_E) : '0;
      if (overflow)
         word = to_inf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
         word = {sign, e_field, m_r[MAN_W-1:0]};
   end

endmodule

// File: rtl/fpu_div_param.sv
// Parametrised IEEE-754 divider: multi-cycle restoring division with
// special-case handling, subnormal support, rounding modes and flags.
module fpu_div_param
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [EXP_W+MAN_W:0]  input_a,
   input  logic [EXP_W+MAN_W:0]  input_b,
   input  logic [2:0]            rm,
   input  logic                  div_input_STB,
   output logic                  div_BUSY,
   output logic [EXP_W+MAN_W:0]  output_div,
   output logic [4:0]            flags,
   output logic                  div_output_STB,
   input  logic                  output_module_BUSY
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int MW   = MAN_W + 1;
   localparam int QW   = MAN_W + 4;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(QW);
   localparam int BIAS = bias(EXP_W);
   localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic signed [EW-1:0] EMIN   = EW'(1 - BIAS);
   localparam logic signed [EW-1:0] ONE_E  = EW'(1);
   localparam logic [63:0]          QNAN64 = canonical_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]         QNAN   = QNAN64[W-1:0];

   logic [3:0]             state;
   logic [W-1:0]           a_raw, b_raw;
   rm_e                    rm_q;
   logic                   res_s;
   logic signed [EW-1:0]   a_e, b_e, e;
   logic [MW-1:0]          a_m, b_m;
   logic [MW:0]            rem;
   logic [QW-1:0]          q;
   logic                   sticky;
   logic                   normed;
   logic [CW-1:0]          cnt;
   logic [W-1:0]           pack_word;
   logic [2:0]             pack_fl;

   logic [EXP_W-1:0]       a_ef, b_ef;
   logic [MAN_W-1:0]       a_f, b_f;
   logic                   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic                   spec_hit;
   logic [W-1:0]           spec_word;
   fpu_flags_t             spec_flags;
   logic [MW:0]            div_in, rem_sub, rem_next;
   logic                   q_bit;
   logic signed [EW-1:0]   e_norm, e_inc;
   logic [W-1:0]           rp_word;
   logic                   rp_ovf, rp_unf, rp_inx;

   assign a_ef = a_raw[W-2:MAN_W];
   assign b_ef = b_raw[W-2:MAN_W];
   assign a_f  = a_raw[MAN_W-1:0];
   assign b_f  = b_raw[MAN_W-1:0];

   assign div_BUSY       = (state != ST_IDLE);
   assign div_output_STB = (state == ST_OUT);

   // Operand classification and special-result selection in priority order
   always_comb begin
      a_nan  = (&a_ef) & (|a_f);
      b_nan  = (&b_ef) & (|b_f);
      a_snan = a_nan & ~a_f[MAN_W-1];
      b_snan = b_nan & ~b_f[MAN_W-1];
      a_inf  = (&a_ef) & ~(|a_f);
      b_inf  = (&b_ef) & ~(|b_f);
      a_zero = ~(|a_ef) & ~(|a_f);
      b_zero = ~(|b_ef) & ~(|b_f);
      spec_hit   = 1'b1;
      spec_word  = QNAN;
      spec_flags = '0;
      if (a_nan | b_nan) begin
         spec_flags.invalid = a_snan | b_snan;
      end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
         spec_flags.invalid = 1'b1;
      end else if (a_inf) begin
         spec_word = {res_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_word = {res_s, {(W-1){1'b0}}};
      end else if (b_zero) begin
         spec_word = {res_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_flags.divzero = 1'b1;
      end else if (a_zero) begin
         spec_word = {res_s, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring-division step; NORM's exit cycle feeds the dividend directly
   always_comb begin
      div_in   = (state == ST_NORM) ? {1'b0, a_m} : rem;
      q_bit    = (div_in >= {1'b0, b_m});
      rem_sub  = q_bit ? (div_in - {1'b0, b_m}) : div_in;
      rem_next = rem_sub << 1;
      e_norm   = q[QW-1] ? e : (e - ONE_E);
      e_inc    = e + ONE_E;
   end

   fp_round_pack #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
   ) u_round_pack (
      .sign      (res_s),
      .exp_in    (e),
      .mant      (q[QW-1:3]),
      .guard     (q[2]),
      .round_bit (q[1]),
      .sticky    (q[0] | sticky),
      .rm        (rm_q),
      .word      (rp_word),
      .overflow  (rp_ovf),
      .underflow (rp_unf),
      .inexact   (rp_inx)
   );

   // Transaction FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         flags <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (div_input_STB) begin
                  a_raw <= input_a;
                  b_raw <= input_b;
                  rm_q  <= (rm > 3'd4) ? RM_RNE : rm_e'(rm);
                  state <= ST_UNPACK;
               end
            end
            ST_UNPACK: begin
               res_s <= a_raw[W-1] ^ b_raw[W-1];
               a_e   <= (a_ef == '0) ? EMIN : ($signed({2'b00, a_ef}) - BIAS_E);
               b_e   <= (b_ef == '0) ? EMIN : ($signed({2'b00, b_ef}) - BIAS_E);
               a_m   <= {(a_ef != '0), a_f};
               b_m   <= {(b_ef != '0), b_f};
               state <= ST_SPECIAL;
            end
            ST_SPECIAL: begin
               if (spec_hit) begin
                  output_div <= spec_word;
                  flags      <= spec_flags;
                  state      <= ST_OUT;
               end else begin
                  state <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (!a_m[MW-1]) begin
                  a_m <= a_m << 1;
                  a_e <= a_e - ONE_E;
               end else if (!b_m[MW-1]) begin
                  b_m <= b_m << 1;
                  b_e <= b_e - ONE_E;
               end else begin
                  // Both operands normalised: the leading quotient bit is
                  // produced here, so DIVIDE only needs QW-1 further cycles.
                  e     <= a_e - b_e;
                  q     <= {{(QW-1){1'b0}}, q_bit};
                  rem   <= rem_next;
                  cnt   <= '0;
                  state <= ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               q   <= {q[QW-2:0], q_bit};
               rem <= rem_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(QW - 2)) begin
                  normed <= 1'b0;
                  state  <= ST_POSTNORM;
               end
            end
            ST_POSTNORM: begin
               if (!normed) begin
                  normed <= 1'b1;
                  sticky <= |rem;
                  if (!q[QW-1]) q <= q << 1;
                  e <= e_norm;
                  if (e_norm >= EMIN) state <= ST_ROUND;
               end else begin
                  q      <= q >> 1;
                  sticky <= sticky | q[0];
                  e      <= e_inc;
                  if (e_inc >= EMIN) state <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               pack_word <= rp_word;
               pack_fl   <= {rp_ovf, rp_unf, rp_inx};
               state     <= ST_PACK;
            end
            ST_PACK: begin
               output_div <= pack_word;
               flags      <= {2'b00, pack_fl};
               state      <= ST_OUT;
            end
            ST_OUT: begin
               if (!output_module_BUSY) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_div_param.sv
// Directed bench for fpu_div_param: single- and half-precision instances,
// rounding modes, specials, overflow/underflow, latency, stall and reset.
module tb_fpu_div_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, down_busy;
   logic [31:0] sp_a, sp_b, sp_out;
   logic [2:0]  sp_rm;
   logic        sp_stb, sp_busy, sp_ostb;
   logic [4:0]  sp_fl;
   logic [15:0] hp_a, hp_b, hp_out;
   logic [2:0]  hp_rm;
   logic        hp_stb, hp_busy, hp_ostb;
   logic [4:0]  hp_fl;

   int checks = 0;
   int errors = 0;

   fpu_div_param #(.EXP_W(8), .MAN_W(23)) u_sp (
      .clk(clk), .rst(rst), .input_a(sp_a), .input_b(sp_b), .rm(sp_rm),
      .div_input_STB(sp_stb), .div_BUSY(sp_busy), .output_div(sp_out),
      .flags(sp_fl), .div_output_STB(sp_ostb), .output_module_BUSY(down_busy)
   );

   fpu_div_param #(.EXP_W(5), .MAN_W(10)) u_hp (
      .clk(clk), .rst(rst), .input_a(hp_a), .input_b(hp_b), .rm(hp_rm),
      .div_input_STB(hp_stb), .div_BUSY(hp_busy), .output_div(hp_out),
      .flags(hp_fl), .div_output_STB(hp_ostb), .output_module_BUSY(down_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_op(input bit hp, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, output logic [31:0] res,
                        output logic [4:0] fl, output int lat);
      @(negedge clk);
      if (hp) begin hp_a = a[15:0]; hp_b = b[15:0]; hp_rm = m; hp_stb = 1'b1; end
      else    begin sp_a = a;       sp_b = b;       sp_rm = m; sp_stb = 1'b1; end
      @(posedge clk);
      #1;
      hp_stb = 1'b0;
      sp_stb = 1'b0;
      lat = 1;
      while (!(hp ? hp_ostb : sp_ostb) && lat < 500) begin
         @(posedge clk); #1; lat++;
      end
      chk("done", {63'd0, (hp ? hp_ostb : sp_ostb)}, 64'd1);
      res = hp ? {16'h0000, hp_out} : sp_out;
      fl  = hp ? hp_fl : sp_fl;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          hp;
      logic [31:0] a, b;
      logic [2:0]  m;
      logic [31:0] q;
      logic [4:0]  f;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] r;
      logic [4:0]  f;
      int          l, n, seen;

      rst = 1'b1; down_busy = 1'b0;
      sp_a = '0; sp_b = '0; sp_rm = '0; sp_stb = 1'b0;
      hp_a = '0; hp_b = '0; hp_rm = '0; hp_stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sp_busy", sp_busy, 0);
      chk("rst_sp_ostb", sp_ostb, 0);
      chk("rst_sp_flags", sp_fl, 0);
      chk("rst_hp_busy", hp_busy, 0);
      chk("rst_hp_ostb", hp_ostb, 0);
      @(negedge clk) rst = 1'b0;

      //             hp  a             b             rm    quotient      flags     lat
      vecs.push_back('{0, 32'h40C00000, 32'h3FC00000, 3'd0, 32'h40800000, 5'b00000, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00001, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 5'b00001, 33});
      vecs.push_back('{0, 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001, 33});
      vecs.push_back('{0, 32'h3F800000, 32'h80000000, 3'd0, 32'hFF800000, 5'b01000, 3});
      vecs.push_back('{0, 32'h00000000, 32'h00000000, 3'd0, 32'hFFC00000, 5'b10000, 3});
      vecs.push_back('{0, 32'h7F800000, 32'h7F800000, 3'd0, 32'hFFC00000, 5'b10000, 3});
      vecs.push_back('{0, 32'h7FC00000, 32'h3F800000, 3'd0, 32'hFFC00000, 5'b00000, 3});
      vecs.push_back('{0, 32'h7F800001, 32'h3F800000, 3'd0, 32'hFFC00000, 5'b10000, 3});
      vecs.push_back('{0, 32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'b00101, 33});
      vecs.push_back('{0, 32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 33});
      vecs.push_back('{1, 32'h00003C00, 32'h00004000, 3'd0, 32'h00003800, 5'b00000, 20});
      vecs.push_back('{1, 32'h00000001, 32'h00003C00, 3'd0, 32'h00000001, 5'b00000, 40});
      vecs.push_back('{0, 32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 5'b00011, 80});

      foreach (vecs[i]) begin
         do_op(vecs[i].hp, vecs[i].a, vecs[i].b, vecs[i].m, r, f, l);
         chk($sformatf("v%0d_q", i), r, vecs[i].q);
         chk($sformatf("v%0d_flags", i), f, vecs[i].f);
         chk($sformatf("v%0d_lat", i), l, vecs[i].lat);
      end

      // Downstream stall: OUT must hold and ignore new strobes
      down_busy = 1'b1;
      @(negedge clk);
      sp_a = 32'h40000000; sp_b = 32'h3F800000; sp_rm = 3'd0; sp_stb = 1'b1;
      @(posedge clk); #1;
      sp_stb = 1'b0;
      n = 0;
      while (!sp_ostb && n < 200) begin @(posedge clk); #1; n++; end
      chk("stall_reach", sp_ostb, 1);
      for (int unsigned i = 0; i < 5; i++) begin
         chk("stall_stb", sp_ostb, 1);
         chk("stall_q", sp_out, 32'h40000000);
         chk("stall_busy", sp_busy, 1);
         @(negedge clk);
         sp_a = 32'h3F800000; sp_b = 32'h40400000;
         sp_stb = (i == 2);
         @(posedge clk); #1;
      end
      sp_stb = 1'b0;
      @(negedge clk) down_busy = 1'b0;
      @(posedge clk); #1;
      chk("stall_rel_stb", sp_ostb, 0);
      chk("stall_rel_busy", sp_busy, 0);
      chk("stall_hold_q", sp_out, 32'h40000000);
      @(posedge clk); #1;
      chk("stall_stays_idle", sp_busy, 0);

      // Reset in the middle of DIVIDE aborts the operation
      @(negedge clk);
      sp_a = 32'h40C00000; sp_b = 32'h3FC00000; sp_rm = 3'd0; sp_stb = 1'b1;
      @(posedge clk); #1;
      sp_stb = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", sp_busy, 0);
      chk("mid_rst_ostb", sp_ostb, 0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (sp_ostb) seen++; end
      chk("mid_rst_no_out", seen, 0);
      do_op(0, 32'h40C00000, 32'h3FC00000, 3'd0, r, f, l);
      chk("post_rst_q", r, 32'h40800000);
      chk("post_rst_flags", f, 5'b00000);
      chk("post_rst_lat", l, 33);

      // Reset clears flags left by a previous inexact result
      do_op(0, 32'h3F800000, 32'h40400000, 3'd0, r, f, l);
      chk("pre_rst_flags", f, 5'b00001);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_clears_flags", sp_fl, 0);
      @(negedge clk) rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
